fetch_queue: RTL and testbench

Instruction buffer between the fetch stage and the decode stage. Accepts one 32-bit instruction plus PC per cycle from fetch, holds up to DEPTH entries in program order, and presents the oldest entry to decode. Decouples fetch from decode stalls and discards all buffered instructions on a fetch kill (branch redirect or exception). When empty, it presents a canonical NOP so decode always sees a harmless instruction.

---
 rtl/fetch_queue_pkg.sv | 12 +
 rtl/fetch_queue_if.sv | 32 +++
 rtl/fetch_queue.sv | 82 ++++++++
 tb/tb_fetch_queue.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/fetch_queue_pkg.sv
// rtl/fetch_queue_pkg.sv - shared widths and the canonical NOP for the fetch/decode boundary
package fetch_queue_pkg;

  localparam int INSN_LEN = 32;
  localparam int ADDR_LEN = 32;
  localparam logic [INSN_LEN-1:0] RV_NOP = 32'h00000013;

  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fetch_queue_if.sv
// rtl/fetch_queue_if.sv - fetch-side enqueue and decode-side head signals of the instruction buffer
interface fetch_queue_if
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = ADDR_LEN
);

  localparam int CNT_W = cnt_width(DEPTH);

  logic                enq_valid_i;
  logic [INSN_LEN-1:0] enq_inst_i;
  logic [ADDR_W-1:0]   enq_pc_i;
  logic                enq_ready_o;
  logic                kill_IF_i;
  logic                stall_ID_i;
  logic [INSN_LEN-1:0] inst1_o;
  logic [ADDR_W-1:0]   pc1_o;
  logic                valid_o;
  logic [CNT_W-1:0]    count_o;

  modport master (
    output enq_valid_i, enq_inst_i, enq_pc_i, kill_IF_i, stall_ID_i,
    input  enq_ready_o, inst1_o, pc1_o, valid_o, count_o
  );

  modport slave (
    input  enq_valid_i, enq_inst_i, enq_pc_i, kill_IF_i, stall_ID_i,
    output enq_ready_o, inst1_o, pc1_o, valid_o, count_o
  );

endinterface

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - in-order instruction buffer between fetch and decode, NOP when empty
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = ADDR_LEN
) (
  input  logic           clk_i,
  input  logic           reset_i,
  fetch_queue_if.slave   q
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = cnt_width(DEPTH);

  logic [PTR_W-1:0]    head_q, head_d;
  logic [PTR_W-1:0]    tail_q, tail_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [INSN_LEN-1:0] inst_mem_q [DEPTH];
  logic [ADDR_W-1:0]   pc_mem_q [DEPTH];

  logic full;
  logic not_empty;
  logic enq_fire;
  logic deq_fire;

  // Ready depends only on occupancy, so a dequeue from full frees the slot one cycle later.
  always_comb begin
    full      = (count_q == CNT_W'(DEPTH));
    not_empty = (count_q != '0);
    enq_fire  = q.enq_valid_i & ~full & ~q.kill_IF_i;
    deq_fire  = not_empty & ~q.stall_ID_i & ~q.kill_IF_i;
  end

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (q.kill_IF_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (deq_fire) head_d = head_q + PTR_W'(1);
      if (enq_fire) tail_d = tail_q + PTR_W'(1);
      case ({enq_fire, deq_fire})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage is deliberately unreset; stale slots are never visible because count gates the head.
  always_ff @(posedge clk_i) begin
    if (enq_fire) begin
      inst_mem_q[tail_q] <= q.enq_inst_i;
      pc_mem_q[tail_q]   <= q.enq_pc_i;
    end
  end

  always_comb begin
    q.enq_ready_o = ~full;
    q.valid_o     = not_empty;
    q.count_o     = count_q;
    q.inst1_o     = not_empty ? inst_mem_q[head_q] : RV_NOP;
    q.pc1_o       = not_empty ? pc_mem_q[head_q] : '0;
  end

endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - randomized self-checking bench for fetch_queue against a queue-based model
module tb_fetch_queue;
  import fetch_queue_pkg::*;

  localparam int DEPTH  = 4;
  localparam int ADDR_W = 32;
  localparam int CNT_W  = $clog2(DEPTH + 1);
  localparam int VEC_W  = 1 + CNT_W + 1 + INSN_LEN + ADDR_W;

  logic clk_i;
  logic reset_i;
  int   n_cmp;
  int   n_bad;

  logic [INSN_LEN+ADDR_W-1:0] mq[$];

  fetch_queue_if #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) bus ();

  fetch_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .q       (bus)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  function automatic logic [VEC_W-1:0] exp_vec();
    logic [INSN_LEN-1:0] i;
    logic [ADDR_W-1:0]   p;
    int                  n;
    n = mq.size();
    i = (n > 0) ? mq[0][INSN_LEN+ADDR_W-1:ADDR_W] : 32'h00000013;
    p = (n > 0) ? mq[0][ADDR_W-1:0] : '0;
    return {n > 0, CNT_W'(n), n != DEPTH, i, p};
  endfunction

  function automatic logic [VEC_W-1:0] act_vec();
    return {bus.valid_o, bus.count_o, bus.enq_ready_o, bus.inst1_o, bus.pc1_o};
  endfunction

  // One clock: model decides what fires from its pre-edge occupancy, then checks happen #1 after the edge.
  task automatic drive_cycle(input logic ev, input logic [31:0] inst, input logic [31:0] pc,
                             input logic stall, input logic kill);
    bit e, d;
    bus.enq_valid_i = ev;
    bus.enq_inst_i  = inst;
    bus.enq_pc_i    = pc;
    bus.stall_ID_i  = stall;
    bus.kill_IF_i   = kill;
    e = ev && (mq.size() < DEPTH) && !kill;
    d = (mq.size() > 0) && !stall && !kill;
    @(posedge clk_i);
    if (kill) mq.delete();
    else begin
      if (d) void'(mq.pop_front());
      if (e) mq.push_back({inst, pc});
    end
    #1;
  endtask

  task automatic test_reset();
    reset_i = 1'b0;
    bus.enq_valid_i = 0; bus.enq_inst_i = 0; bus.enq_pc_i = 0;
    bus.stall_ID_i = 0; bus.kill_IF_i = 0;
    mq.delete();
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    reset_i = 1'b1;
    #1;
    n_cmp++;
    if (act_vec() !== {1'b0, CNT_W'(0), 1'b1, 32'h00000013, 32'h0}) begin
      n_bad++;
      $display("FAIL reset: got %h want %h", act_vec(), {1'b0, CNT_W'(0), 1'b1, 32'h00000013, 32'h0});
    end
  endtask

  task automatic test_fill_drain();
    for (int k = 0; k < 4; k++) drive_cycle(1, 32'hA0 + k, 32'h100 + 4 * k, 1, 0);
    n_cmp++;
    if (bus.count_o !== 3'd4 || bus.enq_ready_o !== 1'b0) begin
      n_bad++;
      $display("FAIL fill_full: count %0d ready %b want 4 0", bus.count_o, bus.enq_ready_o);
    end
    drive_cycle(1, 32'hDEAD, 32'h200, 1, 0);
    n_cmp++;
    if (bus.count_o !== 3'd4 || bus.inst1_o !== 32'hA0) begin
      n_bad++;
      $display("FAIL fill_overflow: count %0d inst %h want 4 000000a0", bus.count_o, bus.inst1_o);
    end
    for (int k = 0; k < 5; k++) begin
      logic [31:0] wi, wp;
      wi = (k < 4) ? 32'hA0 + k : 32'h13;
      wp = (k < 4) ? 32'h100 + 4 * k : 32'h0;
      n_cmp++;
      if (bus.inst1_o !== wi || bus.pc1_o !== wp) begin
        n_bad++;
        $display("FAIL drain_%0d: inst %h pc %h want %h %h", k, bus.inst1_o, bus.pc1_o, wi, wp);
      end
      drive_cycle(0, 0, 0, 0, 0);
    end
  endtask

  task automatic test_steady_stream();
    logic [31:0] prev;
    for (int k = 0; k < 16; k++) begin
      prev = $urandom;
      drive_cycle(1, prev, 32'h400 + 4 * k, 0, 0);
      n_cmp++;
      if (bus.count_o !== 3'd1 || bus.inst1_o !== prev || act_vec() !== exp_vec()) begin
        n_bad++;
        $display("FAIL stream_%0d: got %h want %h (inst want %h)", k, act_vec(), exp_vec(), prev);
      end
    end
    drive_cycle(0, 0, 0, 0, 0);
  endtask

  task automatic test_full_simultaneous();
    for (int k = 0; k < 4; k++) drive_cycle(1, 32'hB0 + k, 32'h500 + 4 * k, 1, 0);
    drive_cycle(1, 32'hCAFE, 32'h600, 0, 0);
    n_cmp++;
    if (bus.count_o !== 3'd3 || bus.enq_ready_o !== 1'b1 || bus.inst1_o !== 32'hB1) begin
      n_bad++;
      $display("FAIL full_simul: count %0d ready %b inst %h want 3 1 000000b1",
               bus.count_o, bus.enq_ready_o, bus.inst1_o);
    end
    drive_cycle(1, 32'hCAFE, 32'h600, 1, 0);
    n_cmp++;
    if (bus.count_o !== 3'd4 || act_vec() !== exp_vec()) begin
      n_bad++;
      $display("FAIL full_retry: got %h want %h", act_vec(), exp_vec());
    end
    for (int k = 0; k < 4; k++) drive_cycle(0, 0, 0, 0, 0);
  endtask

  task automatic test_kill();
    for (int k = 0; k < 3; k++) drive_cycle(1, 32'hC0 + k, 32'h700 + 4 * k, 1, 0);
    drive_cycle(1, 32'hBAD0, 32'h800, 0, 1);
    n_cmp++;
    if (act_vec() !== {1'b0, CNT_W'(0), 1'b1, 32'h00000013, 32'h0}) begin
      n_bad++;
      $display("FAIL kill: got %h want empty", act_vec());
    end
    drive_cycle(1, 32'hD0, 32'h900, 1, 0);
    n_cmp++;
    if (bus.valid_o !== 1'b1 || bus.inst1_o !== 32'hD0 || bus.pc1_o !== 32'h900) begin
      n_bad++;
      $display("FAIL kill_refill: valid %b inst %h pc %h want 1 000000d0 00000900",
               bus.valid_o, bus.inst1_o, bus.pc1_o);
    end
    drive_cycle(0, 0, 0, 0, 0);
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      drive_cycle($urandom_range(0, 3) != 0, $urandom, $urandom, $urandom_range(0, 2) == 0,
                  $urandom_range(0, 24) == 0);
      n_cmp++;
      if (act_vec() !== exp_vec()) begin
        n_bad++;
        $display("FAIL random_%0d: got %h want %h", k, act_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_async_reset();
    drive_cycle(0, 0, 0, 0, 1);
    drive_cycle(1, 32'hE0, 32'hA00, 1, 0);
    drive_cycle(1, 32'hE1, 32'hA04, 1, 0);
    bus.enq_valid_i = 0;
    n_cmp++;
    if (bus.count_o !== 3'd2) begin
      n_bad++;
      $display("FAIL async_pre: count %0d want 2", bus.count_o);
    end
    #2 reset_i = 1'b0;
    mq.delete();
    #1;
    n_cmp++;
    if (act_vec() !== {1'b0, CNT_W'(0), 1'b1, 32'h00000013, 32'h0}) begin
      n_bad++;
      $display("FAIL async_reset: got %h want reset values", act_vec());
    end
    @(negedge clk_i);
    reset_i = 1'b1;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_fill_drain();
    test_steady_stream();
    test_full_simultaneous();
    test_kill();
    test_random();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
